// File: rtl/load_align_unit.sv
// Memory-stage load unit: alignment check, one SRAM-like read per load, byte/half extraction.
// Result is registered; stallM holds the pipeline from issue until data returns (min 2 stall cycles).
module load_align_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        loadM,
  input  logic [7:0]  alucontrolM,
  input  logic [31:0] addressM,
  input  logic        flushM,
  input  logic        stall_ext,
  output logic        adelM,
  output logic        stallM,
  output logic [31:0] resultM,
  output logic        result_valid,
  output logic        data_req,
  output logic [31:0] data_addr,
  output logic [1:0]  data_size,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic [7:0]  op_q;
  logic [1:0]  size_q;
  logic [31:0] result_q;

  logic       is_byte, is_half, is_word, is_load, misalign, start, capture;
  logic [1:0] size_live;

  function automatic logic [31:0] extract(input logic [7:0] op, input logic [1:0] off,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[7:0];
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      EXE_LB_OP:  extract = {{24{b[7]}}, b};
      EXE_LBU_OP: extract = {24'd0, b};
      EXE_LH_OP:  extract = {{16{h[15]}}, h};
      EXE_LHU_OP: extract = {16'd0, h};
      default:    extract = rd;
    endcase
  endfunction

  always_comb begin
    is_byte   = (alucontrolM == EXE_LB_OP) || (alucontrolM == EXE_LBU_OP);
    is_half   = (alucontrolM == EXE_LH_OP) || (alucontrolM == EXE_LHU_OP);
    is_word   = (alucontrolM == EXE_LW_OP);
    is_load   = is_byte || is_half || is_word;
    misalign  = (is_half && addressM[0]) || (is_word && (addressM[1:0] != 2'b00));
    size_live = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    start     = resetn && (state_q == S_IDLE) && loadM && is_load && !misalign && !flushM;
    capture   = (state_q == S_WAIT) && data_data_ok && !flushM;
  end

  // An accepted request must always see its data_ok, so flushes after acceptance go via DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = data_addr_ok ? S_WAIT : S_REQ;
      S_REQ: begin
        if (data_addr_ok)  state_d = flushM ? S_DRAIN : S_WAIT;
        else if (flushM)   state_d = S_IDLE;
      end
      S_WAIT: begin
        if (data_data_ok)  state_d = flushM ? S_IDLE : S_DONE;
        else if (flushM)   state_d = S_DRAIN;
      end
      S_DRAIN: if (data_data_ok) state_d = S_IDLE;
      S_DONE:  if (!stall_ext || flushM) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'd0;
      op_q     <= 8'd0;
      size_q   <= 2'd0;
      result_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q <= addressM;
        op_q   <= alucontrolM;
        size_q <= size_live;
      end
      if (capture) result_q <= extract(op_q, addr_q[1:0], data_rdata);
    end
  end

  always_comb begin
    adelM        = resetn && loadM && misalign;
    data_req     = resetn && (start || (state_q == S_REQ));
    data_addr    = (state_q == S_IDLE) ? addressM : addr_q;
    data_size    = (state_q == S_IDLE) ? size_live : size_q;
    stallM       = resetn && (start || (state_q == S_REQ) || (state_q == S_WAIT) ||
                              (state_q == S_DRAIN));
    result_valid = (state_q == S_DONE);
    resultM      = result_q;
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: per-transaction timeline model plus a per-cycle compare process.
module tb_load_align_unit;

  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] LW  = 8'b1110_0011;

  logic        clk = 1'b0;
  logic        resetn;
  logic        loadM;
  logic [7:0]  alucontrolM;
  logic [31:0] addressM;
  logic        flushM;
  logic        stall_ext;
  logic        adelM;
  logic        stallM;
  logic [31:0] resultM;
  logic        result_valid;
  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk_en;
  logic        exp_adel, exp_stall, exp_req, exp_valid;
  logic [31:0] exp_result, exp_addr;
  logic [1:0]  exp_size;

  load_align_unit dut (
    .clk(clk), .resetn(resetn), .loadM(loadM), .alucontrolM(alucontrolM),
    .addressM(addressM), .flushM(flushM), .stall_ext(stall_ext), .adelM(adelM),
    .stallM(stallM), .resultM(resultM), .result_valid(result_valid),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] rd);
    int unsigned off;
    logic [31:0] v;
    off = addr % 4;
    if (op == LB || op == LBU) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (op == LB && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (op == LH || op == LHU) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (op == LH && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic model_adel(input logic [7:0] op, input logic [31:0] addr);
    return ((op == LH || op == LHU) && (addr % 2 != 0)) || (op == LW && (addr % 4 != 0));
  endfunction

  function automatic logic [1:0] model_size(input logic [7:0] op);
    if (op == LW) return 2'd2;
    if (op == LH || op == LHU) return 2'd1;
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("adelM", {31'd0, adelM}, {31'd0, exp_adel});
      check("stallM", {31'd0, stallM}, {31'd0, exp_stall});
      check("data_req", {31'd0, data_req}, {31'd0, exp_req});
      check("result_valid", {31'd0, result_valid}, {31'd0, exp_valid});
      check("resultM", resultM, exp_result);
      if (exp_req) begin
        check("data_addr", data_addr, exp_addr);
        check("data_size", {30'd0, data_size}, {30'd0, exp_size});
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    loadM = 1'b0; flushM = 1'b0; stall_ext = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
    exp_adel = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_valid = 1'b0;
    @(negedge clk);
  endtask

  // a: cycles before addr_ok; d: extra cycles before data_ok; s: stall_ext cycles in DONE;
  // fc: cycle of flushM (-1 for none).
  task automatic run_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rd,
                          input int a, input int d, input int s, input int fc);
    logic adel, drop;
    int t_data, last_stall, v_first, v_last, ld_last, total;
    adel       = model_adel(op, addr);
    drop       = (fc >= 1) && (fc < a);
    t_data     = a + 1 + d;
    last_stall = adel ? -1 : (drop ? fc : t_data);
    v_first    = (fc < 0 && !adel) ? t_data + 1 : 1000;
    v_last     = t_data + 1 + s;
    ld_last    = adel ? 0 : ((fc >= 0) ? fc : v_last);
    total      = adel ? 1 : ((fc >= 0) ? last_stall + 2 : v_last + 1);
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      loadM        = (c <= ld_last);
      alucontrolM  = op;
      addressM     = addr;
      flushM       = (c == fc);
      data_addr_ok = !adel && !drop && (c == a);
      data_data_ok = !adel && !drop && (c == t_data);
      data_rdata   = data_data_ok ? rd : $urandom;
      stall_ext    = (c >= v_first) && (c < v_last);
      exp_adel     = adel && (c == 0);
      exp_req      = !adel && (c <= (drop ? fc : a));
      exp_stall    = !adel && (c <= last_stall);
      exp_valid    = (c >= v_first) && (c <= v_last);
      exp_addr     = addr;
      exp_size     = model_size(op);
      if (c == v_first) exp_result = model_result(op, addr, rd);
      @(negedge clk);
    end
    idle_cycle();
  endtask

  initial begin
    resetn = 1'b0; loadM = 1'b0; alucontrolM = 8'd0; addressM = 32'd0; flushM = 1'b0;
    stall_ext = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    exp_adel = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_valid = 1'b0;
    exp_result = 32'd0; exp_addr = 32'd0; exp_size = 2'd0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);

    run_load(LBU, 32'h1000_0001, 32'h8899_AABB, 0, 0, 0, -1);
    check("lit_lbu", resultM, 32'h0000_00AA);
    run_load(LB,  32'h1000_0001, 32'h8899_AABB, 0, 0, 0, -1);
    check("lit_lb", resultM, 32'hFFFF_FFAA);
    run_load(LH,  32'h1000_0002, 32'h8000_1234, 0, 0, 0, -1);
    check("lit_lh", resultM, 32'hFFFF_8000);
    run_load(LHU, 32'h1000_0000, 32'h8000_1234, 0, 0, 0, -1);
    check("lit_lhu", resultM, 32'h0000_1234);
    run_load(LW,  32'h1000_0000, 32'hDEAD_BEEF, 0, 0, 0, -1);
    check("lit_lw", resultM, 32'hDEAD_BEEF);
    run_load(LW,  32'h1000_0002, 32'h1111_2222, 0, 0, 0, -1);
    run_load(LH,  32'h1000_0001, 32'h1111_2222, 0, 0, 0, -1);
    check("lit_adel_hold", resultM, 32'hDEAD_BEEF);
    run_load(LB,  32'h1000_0003, 32'h8899_AABB, 0, 0, 0, -1);
    check("lit_lb_top", resultM, 32'hFFFF_FF88);
    run_load(LHU, 32'h2000_0006, 32'hCAFE_0001, 3, 1, 0, -1);
    check("lit_backpressure", resultM, 32'h0000_CAFE);
    run_load(LBU, 32'h2000_0102, 32'h0055_0000, 0, 2, 0, 2);
    run_load(LW,  32'h2000_0200, 32'h1234_5678, 3, 0, 0, 1);
    check("lit_flush_hold", resultM, 32'h0000_CAFE);
    run_load(LB,  32'h3000_0000, 32'h0000_007F, 1, 0, 2, -1);
    check("lit_held", resultM, 32'h0000_007F);

    // Reset asserted while the read is outstanding.
    @(posedge clk); #1;
    loadM = 1'b1; alucontrolM = LW; addressM = 32'h4000_0010; data_addr_ok = 1'b1;
    exp_req = 1'b1; exp_stall = 1'b1; exp_addr = 32'h4000_0010; exp_size = 2'd2;
    @(negedge clk);
    @(posedge clk); #1;
    data_addr_ok = 1'b0; exp_req = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("rst_stallM", {31'd0, stallM}, 32'd0);
    check("rst_data_req", {31'd0, data_req}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_resultM", resultM, 32'd0);
    @(posedge clk); #1;
    loadM = 1'b0; resetn = 1'b1;
    exp_adel = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_valid = 1'b0; exp_result = 32'd0;
    chk_en = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    idle_cycle();
    idle_cycle();
    run_load(LHU, 32'h4000_0002, 32'hBEEF_0000, 0, 0, 0, -1);
    check("lit_after_reset", resultM, 32'h0000_BEEF);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
